mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle main control FSM for the MIPS core. It sequences the program counter, instruction register, register file, ALU and unified memory port for one instruction at a time. It drives PC update strobes and source selects in place of the single-cycle pcSrc/jump/zFlag decode. Memory accesses wait on a ready handshake. The block counts retired instructions.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
- opcode  in  6  instr[31:26] from instruction register
- zFlag  in  1  ALU zero flag (valid in BRANCH state)
- mem_ready  in  1  memory completes current read/write this cycle
- pcEn  out  1  PC register load enable
- pcSrc  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = {PC[31:28], instr[25:0], 2'b00}
- irWrite  out  1  instruction register load
- iorD  out  1  0 = memory address from PC, 1 = from ALUOut
- memRead, memWrite  out  1 each  memory strobes
- memToReg, regDst, regWrite  out  1 each  register-file write controls
- aluSrcA  out  1  0 = PC, 1 = regA
- aluSrcB  out  2  00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- aluOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- illegal  out  1  one-cycle pulse on unknown opcode
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired  out  CNT_W  count of retired instructions
- state  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00. pcEn and irWrite equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (precomputes branch target). Dispatch on opcode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode: illegal=1, next state FETCH, no retire.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Go to MEMRD for lw, MEMWR for sw; opcode is held stable by the IR.
- MEMRD: memRead=1, iorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0. Retire; go to FETCH.
- MEMWR: memWrite=1, iorD=1. Wait for mem_ready, then retire and go to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10; go to ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0. Retire; go to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcEn=zFlag. Retire; go to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00; go to ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0. Retire; go to FETCH.
- JUMP: pcSrc=10, pcEn=1. Retire; go to FETCH.
- Any output not listed for a state is 0 in that state.
- Retire: instr_done=1 for one cycle, and retired increments by 1 on that same clock edge. The counter wraps from 2^CNT_W−1 to 0.

## Timing
- Outputs are combinational from state, plus opcode/zFlag/mem_ready where stated above.
- While rst=0, every output is forced to 0, including state=0 and retired=0.
- On the edge where rst=0 is sampled, state goes to FETCH and retired goes to 0. This applies mid-instruction too, including during a memory wait, and no partial retire occurs.
- The first fetch begins in the first cycle with rst=1.
- Latency with mem_ready tied to 1:
  - lw 5 cycles
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2 (no retire)
- Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes stay asserted and pcEn/irWrite stay 0 until mem_ready is high.
- At most one pcEn pulse per FETCH. Branch/jump pcEn occurs only in BRANCH or JUMP.

## Test plan
- Reset: hold rst=0 for 3 cycles with mem_ready=1 → all outputs 0. Release → FETCH with memRead=1, pcEn=1, irWrite=1; retired=0.
- Instruction mix with mem_ready=1:
  - Sequence lw, sw, R-type, addi, j → state traces 0,1,2,3,4 | 0,1,2,5 | 0,1,6,7 | 0,1,9,10 | 0,1,11.
  - retired=5 after the j instruction retires.
  - JUMP drives pcSrc=10 with pcEn=1.
- beq with zFlag=1 → BRANCH has pcEn=1, pcSrc=01. With zFlag=0 → pcEn=0 in BRANCH. Both retire.
- Wait states: mem_ready=0 for 2 cycles in FETCH and 3 in MEMRD → lw takes 10 cycles; pcEn/irWrite are asserted only in the ready cycle.
- Illegal opcode 111111 → illegal pulses once in DECODE, return to FETCH, no instr_done, retired unchanged.
- Edge cases:
  - rst=0 during MEMRD wait → FETCH next cycle, no retire.
  - With CNT_W=4, 16 retirements wrap retired back to 0.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the MIPS core: sequences PC, IR, register file,
// ALU and the unified memory port one instruction at a time, and counts retirements.
module mc_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zFlag,
   input  logic             mem_ready,
   output logic             pcEn,
   output logic [1:0]       pcSrc,
   output logic             irWrite,
   output logic             iorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             memToReg,
   output logic             regDst,
   output logic             regWrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic             illegal,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
      logic       instr_done;
   } ctrl_t;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   ctrl_t            ctrl, ctrl_o;

   always_comb begin
      state_d = S_FETCH;
      ctrl    = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.pc_en     = mem_ready;
            ctrl.ir_write  = mem_ready;
            state_d        = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is decoded
            ctrl.alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      ctrl.illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            state_d        = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.ior_d    = 1'b1;
            state_d       = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.ior_d      = 1'b1;
            ctrl.instr_done = mem_ready;
            state_d         = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 2'b10;
            state_d        = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_op     = 2'b01;
            ctrl.pc_src     = 2'b01;
            ctrl.pc_en      = zFlag;
            ctrl.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            state_d        = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_src     = 2'b10;
            ctrl.pc_en      = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, ctrl.instr_done};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Reset is level-visible on the outputs, not just sampled at the edge
   assign ctrl_o  = rst ? ctrl : '0;
   assign state   = rst ? state_q : 4'd0;
   assign retired = rst ? retired_q : '0;

   assign pcEn       = ctrl_o.pc_en;
   assign pcSrc      = ctrl_o.pc_src;
   assign irWrite    = ctrl_o.ir_write;
   assign iorD       = ctrl_o.ior_d;
   assign memRead    = ctrl_o.mem_read;
   assign memWrite   = ctrl_o.mem_write;
   assign memToReg   = ctrl_o.mem_to_reg;
   assign regDst     = ctrl_o.reg_dst;
   assign regWrite   = ctrl_o.reg_write;
   assign aluSrcA    = ctrl_o.alu_src_a;
   assign aluSrcB    = ctrl_o.alu_src_b;
   assign aluOp      = ctrl_o.alu_op;
   assign illegal    = ctrl_o.illegal;
   assign instr_done = ctrl_o.instr_done;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: a directed instruction-mix table, hand sequences for waits,
// reset and counter wrap, and random traffic checked against an instruction-path model.
module tb_mc_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zFlag;
   logic       mem_ready;

   logic        pcEn, irWrite, iorD, memRead, memWrite, memToReg, regDst, regWrite, aluSrcA;
   logic [1:0]  pcSrc, aluSrcB, aluOp;
   logic        illegal, instr_done;
   logic [15:0] retired;
   logic [3:0]  state;

   logic        pcEn_4, irWrite_4, iorD_4, memRead_4, memWrite_4, memToReg_4, regDst_4, regWrite_4, aluSrcA_4;
   logic [1:0]  pcSrc_4, aluSrcB_4, aluOp_4;
   logic        illegal_4, instr_done_4;
   logic [3:0]  retired_4;
   logic [3:0]  state_4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mc_control #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zFlag(zFlag), .mem_ready(mem_ready),
      .pcEn(pcEn), .pcSrc(pcSrc), .irWrite(irWrite), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .illegal(illegal),
      .instr_done(instr_done), .retired(retired), .state(state)
   );

   mc_control #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .opcode(opcode), .zFlag(zFlag), .mem_ready(mem_ready),
      .pcEn(pcEn_4), .pcSrc(pcSrc_4), .irWrite(irWrite_4), .iorD(iorD_4), .memRead(memRead_4),
      .memWrite(memWrite_4), .memToReg(memToReg_4), .regDst(regDst_4), .regWrite(regWrite_4),
      .aluSrcA(aluSrcA_4), .aluSrcB(aluSrcB_4), .aluOp(aluOp_4), .illegal(illegal_4),
      .instr_done(instr_done_4), .retired(retired_4), .state(state_4)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pcen;
      logic [1:0] pcsrc;
      logic       irw, iord, memr, memw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop;
      logic       ill, done;
   } outs_t;

   typedef struct {
      logic [5:0] op;
      bit         z, rdy;
      int         st;
      bit         pcen;
      int         pcsrc;
      bit         irw, memr, ill, done;
      int         ret;
   } vec_t;

   function automatic outs_t act16();
      return {state, pcEn, pcSrc, irWrite, iorD, memRead, memWrite, memToReg, regDst,
              regWrite, aluSrcA, aluSrcB, aluOp, illegal, instr_done};
   endfunction

   function automatic outs_t act4();
      return {state_4, pcEn_4, pcSrc_4, irWrite_4, iorD_4, memRead_4, memWrite_4, memToReg_4,
              regDst_4, regWrite_4, aluSrcA_4, aluSrcB_4, aluOp_4, illegal_4, instr_done_4};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit legal_op(input logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
   endfunction

   // Expected control outputs for one step of an instruction's path
   function automatic outs_t model_outs(input int st, input logic [5:0] op, input bit z, input bit rdy);
      outs_t o;
      o    = '0;
      o.st = 4'(st);
      case (st)
         0:  begin o.memr = 1; o.asb = 2'b01; o.pcen = rdy; o.irw = rdy; end
         1:  begin o.asb = 2'b11; o.ill = !legal_op(op); end
         2:  begin o.asa = 1; o.asb = 2'b10; end
         3:  begin o.memr = 1; o.iord = 1; end
         4:  begin o.rw = 1; o.m2r = 1; o.done = 1; end
         5:  begin o.memw = 1; o.iord = 1; o.done = rdy; end
         6:  begin o.asa = 1; o.aop = 2'b10; end
         7:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
         8:  begin o.asa = 1; o.aop = 2'b01; o.pcsrc = 2'b01; o.pcen = z; o.done = 1; end
         9:  begin o.asa = 1; o.asb = 2'b10; end
         10: begin o.rw = 1; o.done = 1; end
         11: begin o.pcsrc = 2'b10; o.pcen = 1; o.done = 1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   // Instruction-level model: the path of states an opcode walks through
   int         path[$];
   int         pidx;
   int         m_ret;
   logic [5:0] cur_op;

   task automatic start_instr(input logic [5:0] op);
      cur_op = op;
      opcode = op;
      case (op)
         6'h23:   path = '{0, 1, 2, 3, 4};
         6'h2b:   path = '{0, 1, 2, 5};
         6'h00:   path = '{0, 1, 6, 7};
         6'h08:   path = '{0, 1, 9, 10};
         6'h04:   path = '{0, 1, 8};
         6'h02:   path = '{0, 1, 11};
         default: path = '{0, 1};
      endcase
      pidx = 0;
   endtask

   task automatic mstep(input bit rdy, input bit z);
      int st;
      mem_ready = rdy;
      zFlag     = z;
      st        = path[pidx];
      @(negedge clk);
      chk("outs", 32'(act16()), 32'(model_outs(st, cur_op, z, rdy)));
      chk("outs4", 32'(act4()), 32'(model_outs(st, cur_op, z, rdy)));
      chk("retired", 32'(retired), 32'(m_ret % 65536));
      chk("retired4", 32'(retired_4), 32'(m_ret % 16));
      @(posedge clk);
      #1;
      if (!(st inside {0, 3, 5}) || rdy) begin
         pidx++;
         if (pidx == path.size() && legal_op(cur_op)) m_ret++;
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input bit rand_rdy, output int cycles);
      start_instr(op);
      cycles = 0;
      while (pidx < path.size() && cycles < 100) begin
         mstep(rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, 1'($urandom_range(0, 1)));
         cycles++;
      end
   endtask

   vec_t tbl[$];

   initial begin
      int         cyc;
      int         ret_before;
      bit         rp[10];
      logic [5:0] ops[8];

      tbl = '{
         '{6'h23,0,1, 0,1,0,1,1,0,0, 0}, '{6'h23,0,1, 1,0,0,0,0,0,0, 0},
         '{6'h23,0,1, 2,0,0,0,0,0,0, 0}, '{6'h23,0,1, 3,0,0,0,1,0,0, 0},
         '{6'h23,0,1, 4,0,0,0,0,0,1, 0},
         '{6'h2b,0,1, 0,1,0,1,1,0,0, 1}, '{6'h2b,0,1, 1,0,0,0,0,0,0, 1},
         '{6'h2b,0,1, 2,0,0,0,0,0,0, 1}, '{6'h2b,0,1, 5,0,0,0,0,0,1, 1},
         '{6'h00,0,1, 0,1,0,1,1,0,0, 2}, '{6'h00,0,1, 1,0,0,0,0,0,0, 2},
         '{6'h00,0,1, 6,0,0,0,0,0,0, 2}, '{6'h00,0,1, 7,0,0,0,0,0,1, 2},
         '{6'h08,0,1, 0,1,0,1,1,0,0, 3}, '{6'h08,0,1, 1,0,0,0,0,0,0, 3},
         '{6'h08,0,1, 9,0,0,0,0,0,0, 3}, '{6'h08,0,1,10,0,0,0,0,0,1, 3},
         '{6'h02,0,1, 0,1,0,1,1,0,0, 4}, '{6'h02,0,1, 1,0,0,0,0,0,0, 4},
         '{6'h02,0,1,11,1,2,0,0,0,1, 4}
      };

      // Reset held for three cycles: everything reads zero
      rst = 1'b0; mem_ready = 1'b1; zFlag = 1'b0; opcode = 6'h23;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outs", 32'(act16()), 32'd0);
         chk("reset_retired", 32'(retired), 32'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;

      // Directed mix: lw, sw, R-type, addi, j
      foreach (tbl[i]) begin
         opcode = tbl[i].op; zFlag = tbl[i].z; mem_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("mix%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("mix%0d_ctl", i), {26'd0, pcEn, pcSrc, irWrite, memRead, illegal, instr_done},
             {26'd0, tbl[i].pcen, 2'(tbl[i].pcsrc), tbl[i].irw, tbl[i].memr, tbl[i].ill, tbl[i].done});
         chk($sformatf("mix%0d_ret", i), 32'(retired), 32'(tbl[i].ret));
         @(posedge clk);
         #1;
      end
      #2;
      chk("mix_retired5", 32'(retired), 32'd5);
      m_ret = 5;

      // beq taken and not taken
      start_instr(6'h04);
      while (pidx < path.size()) mstep(1'b1, 1'b1);
      start_instr(6'h04);
      while (pidx < path.size()) mstep(1'b1, 1'b0);
      chk("beq_retired", 32'(retired), 32'd7);

      // lw with 2 fetch waits and 3 MEMRD waits
      rp = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
      start_instr(6'h23);
      cyc = 0;
      while (pidx < path.size() && cyc < 20) begin
         mstep(cyc < 10 ? rp[cyc] : 1'b1, 1'b0);
         cyc++;
      end
      chk("lw_wait_cycles", 32'(cyc), 32'd10);

      // Illegal opcode: no retirement
      ret_before = m_ret;
      run_instr(6'h3f, 1'b0, cyc);
      chk("ill_cycles", 32'(cyc), 32'd2);
      #2;
      chk("ill_no_retire", 32'(retired), 32'(ret_before));

      // Reset during an MEMRD wait
      start_instr(6'h23);
      mstep(1'b1, 1'b0); mstep(1'b1, 1'b0); mstep(1'b1, 1'b0); mstep(1'b0, 1'b0);
      rst = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("midwait_rst_outs", 32'(act16()), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_ret = 0;

      // 16 retirements wrap the 4-bit counter
      for (int i = 0; i < 16; i++) run_instr(6'h02, 1'b0, cyc);
      #2;
      chk("wrap4_zero", 32'(retired_4), 32'd0);
      chk("cnt16_sixteen", 32'(retired), 32'd16);

      // Random traffic with random memory stalls and zero flag
      ops = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h04, 6'h02, 6'h3f, 6'h11};
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 7) == 0) run_instr(6'($urandom_range(0, 63)), 1'b1, cyc);
         else run_instr(ops[$urandom_range(0, 7)], 1'b1, cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
